// File: rtl/mips_pkg.sv
// Shared types and constants for the multi-cycle MIPS fetch path.
// No logic lives here; latency and backpressure are properties of the users.
// Contents: fetch FSM state enum, bus widths, PC step and reset PC default.
package mips_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    localparam logic [ADDR_W-1:0] PC_STEP          = 32'd4;
    localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } fetch_state_e;

    // Instruction addresses are word aligned; drop the byte-offset bits.
    function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory read port: req/addr from the fetch unit, ready/rdata back.
// req and addr are registered by the master and held stable until ready.
// The slave stalls the master simply by keeping ready low.
interface instr_fetch_unit_if;
    import mips_pkg::*;

    logic               req;
    logic [ADDR_W-1:0]  addr;
    logic               ready;
    logic [INSTR_W-1:0] rdata;

    modport master (output req, output addr, input ready, input rdata);
    modport slave  (input req, input addr, output ready, output rdata);

endinterface

// File: rtl/pc_reg.sv
// PC register with a one-entry pending-load slot and alignment check.
// pc_o is registered; eff_pc_o/align_err_o are combinational from pc_load_i.
// Loads arriving while busy are parked (latest wins) and applied on return to IDLE.
// Ports: clk/reset; pc_load_i/pc_next_i target; busy_i, adv_en_i/adv_val_i (+4 update),
//        apply_pend_i (busy->IDLE edge); pc_o, eff_pc_o, align_err_o.
module pc_reg
    import mips_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pc_load_i,
    input  logic [ADDR_W-1:0] pc_next_i,
    input  logic              busy_i,
    input  logic              adv_en_i,
    input  logic [ADDR_W-1:0] adv_val_i,
    input  logic              apply_pend_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [ADDR_W-1:0] eff_pc_o,
    output logic              align_err_o
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pend_q, pend_d;
    logic              pend_vld_q, pend_vld_d;
    logic [ADDR_W-1:0] target;

    assign target      = align_word(pc_next_i);
    assign eff_pc_o    = pc_load_i ? target : pc_q;
    assign align_err_o = pc_load_i && (pc_next_i[1:0] != 2'b00);
    assign pc_o        = pc_q;

    always_comb begin
        pc_d       = pc_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        if (!busy_i) begin
            if (pc_load_i) begin
                pc_d = target;
            end
            pend_vld_d = 1'b0;
        end else if (apply_pend_i) begin
            // A load sampled on the very cycle we return to IDLE is newer
            // than anything parked, so it takes priority.
            if (pc_load_i) begin
                pc_d = target;
            end else if (pend_vld_q) begin
                pc_d = pend_q;
            end
            pend_vld_d = 1'b0;
        end else begin
            if (adv_en_i) begin
                pc_d = adv_val_i;
            end
            if (pc_load_i) begin
                pend_vld_d = 1'b1;
                pend_d     = target;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch unit: owns PC and IR, reads one word per fetch_req over the imem port.
// Latency: fetch_req at N -> imem.req at N+1 -> instr_valid at N+2 with zero-wait memory.
// Backpressure: waits on imem.ready up to WAIT_MAX cycles, then aborts with fetch_err.
// Ports: clk/reset; fetch_req, pc_load/pc_next from control; imem master port;
//        Instr, instr_valid, pc, pc_plus4, busy, fetch_err, align_err outputs.
module instr_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int                WAIT_MAX = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fetch_req,
    input  logic                 pc_load,
    input  logic [ADDR_W-1:0]    pc_next,
    instr_fetch_unit_if.master   imem,
    output logic [INSTR_W-1:0]   Instr,
    output logic                 instr_valid,
    output logic [ADDR_W-1:0]    pc,
    output logic [ADDR_W-1:0]    pc_plus4,
    output logic                 busy,
    output logic                 fetch_err,
    output logic                 align_err
);

    localparam int CNT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_MAX - 1);

    fetch_state_e       state_q, state_d;
    logic               imem_req_q, imem_req_d;
    logic [ADDR_W-1:0]  imem_addr_q, imem_addr_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               ready_ok;
    logic               adv_en;
    logic               apply_pend;
    logic               abort;
    logic               align_raw;
    logic [ADDR_W-1:0]  eff_pc;
    logic [ADDR_W-1:0]  pc_cur;

    // ready only counts while our request is actually outstanding.
    assign ready_ok = imem.ready && imem_req_q;

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk          (clk),
        .reset        (reset),
        .pc_load_i    (pc_load),
        .pc_next_i    (pc_next),
        .busy_i       (state_q != IDLE),
        .adv_en_i     (adv_en),
        .adv_val_i    (imem_addr_q + PC_STEP),
        .apply_pend_i (apply_pend),
        .pc_o         (pc_cur),
        .eff_pc_o     (eff_pc),
        .align_err_o  (align_raw)
    );

    always_comb begin
        state_d     = state_q;
        imem_req_d  = imem_req_q;
        imem_addr_d = imem_addr_q;
        instr_d     = instr_q;
        cnt_d       = cnt_q;
        adv_en      = 1'b0;
        apply_pend  = 1'b0;
        abort       = 1'b0;
        case (state_q)
            IDLE: begin
                if (fetch_req) begin
                    state_d     = REQ;
                    imem_req_d  = 1'b1;
                    imem_addr_d = eff_pc;
                    cnt_d       = '0;
                end
            end
            REQ: begin
                if (ready_ok) begin
                    state_d    = DONE;
                    instr_d    = imem.rdata;
                    imem_req_d = 1'b0;
                    adv_en     = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d    = IDLE;
                    imem_req_d = 1'b0;
                    abort      = 1'b1;
                    apply_pend = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d    = IDLE;
                apply_pend = 1'b1;
            end
            default: begin
                state_d    = IDLE;
                imem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            imem_req_q  <= 1'b0;
            imem_addr_q <= '0;
            instr_q     <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            imem_req_q  <= imem_req_d;
            imem_addr_q <= imem_addr_d;
            instr_q     <= instr_d;
            cnt_q       <= cnt_d;
        end
    end

    assign imem.req    = imem_req_q;
    assign imem.addr   = imem_addr_q;
    assign Instr       = instr_q;
    assign instr_valid = (state_q == DONE);
    assign pc          = pc_cur;
    assign pc_plus4    = pc_cur + PC_STEP;
    assign busy        = (state_q != IDLE);
    // Pulses describe events that actually take effect, so a reset cycle suppresses them.
    assign fetch_err   = abort && !reset;
    assign align_err   = align_raw && !reset;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed table, corner sequences, random fetches.
// Inputs are driven after the falling edge and outputs sampled 1 time unit later.
// Memory latency is chosen per fetch; the reference model works per transaction.
module tb_instr_fetch_unit;

    localparam int          WAIT_MAX = 16;
    localparam logic [31:0] RST_PC   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_req;
    logic        pc_load;
    logic [31:0] pc_next;
    logic [31:0] Instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        busy;
    logic        fetch_err;
    logic        align_err;

    instr_fetch_unit_if imem_if ();

    instr_fetch_unit #(
        .RESET_PC (RST_PC),
        .WAIT_MAX (WAIT_MAX)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .fetch_req   (fetch_req),
        .pc_load     (pc_load),
        .pc_next     (pc_next),
        .imem        (imem_if),
        .Instr       (Instr),
        .instr_valid (instr_valid),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .busy        (busy),
        .fetch_err   (fetch_err),
        .align_err   (align_err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state: architectural PC and IR after each completed transaction.
    logic [31:0] m_pc;
    logic [31:0] m_instr;

    typedef struct {
        bit          ld;        // pc_load together with fetch_req
        logic [31:0] tgt;
        int          lat;       // REQ cycles before ready; >= WAIT_MAX means never
        bit          mid_ld;    // pc_load while busy
        int          mid_at;    // REQ cycle index of that load
        logic [31:0] mid_tgt;
        logic [31:0] rdata;
        logic [31:0] exp_addr;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One complete fetch transaction. With use_tbl the address/PC expectations come
    // from the vector itself, otherwise from the transaction-level model.
    task automatic do_fetch(input vec_t v, input bit use_tbl);
        logic [31:0] exp_addr;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
        bit          ok;

        ok        = (v.lat < WAIT_MAX);
        exp_addr  = v.ld ? {v.tgt[31:2], 2'b00} : m_pc;
        exp_instr = ok ? v.rdata : m_instr;
        if (v.mid_ld)  exp_pc = {v.mid_tgt[31:2], 2'b00};
        else if (ok)   exp_pc = exp_addr + 32'd4;
        else           exp_pc = exp_addr;
        if (use_tbl) begin
            exp_addr = v.exp_addr;
            exp_pc   = v.exp_pc;
        end

        // IDLE cycle: request accepted; a stray ready here must be ignored.
        fetch_req     = 1'b1;
        pc_load       = v.ld;
        pc_next       = v.tgt;
        imem_if.ready = 1'($urandom % 2);
        imem_if.rdata = $urandom;
        #1;
        chk("idle_busy", busy, 0);
        chk("idle_req", imem_if.req, 0);
        chk("align_err", align_err, (v.ld && v.tgt[1:0] != 2'b00));
        @(negedge clk);

        for (int k = 0; k < WAIT_MAX; k++) begin
            imem_if.ready = (k == v.lat);
            imem_if.rdata = (k == v.lat) ? v.rdata : $urandom;
            fetch_req     = 1'($urandom % 2);
            pc_load       = v.mid_ld && (k == v.mid_at);
            pc_next       = v.mid_tgt;
            #1;
            chk("req_high", imem_if.req, 1);
            chk("addr_stable", imem_if.addr, exp_addr);
            chk("pc_hold_req", pc, exp_addr);
            chk("fetch_err", fetch_err, (!ok && k == WAIT_MAX - 1));
            chk("no_valid_req", instr_valid, 0);
            @(negedge clk);
            if (k == v.lat) break;
        end
        imem_if.ready = 1'b0;
        pc_load       = 1'b0;

        if (ok) begin
            fetch_req = 1'($urandom % 2);
            #1;
            chk("valid_pulse", instr_valid, 1);
            chk("instr_done", Instr, v.rdata);
            chk("req_drop", imem_if.req, 0);
            @(negedge clk);
        end

        fetch_req = 1'b0;
        #1;
        chk("end_busy", busy, 0);
        chk("end_req", imem_if.req, 0);
        chk("end_valid", instr_valid, 0);
        chk("end_err", fetch_err, 0);
        chk("end_pc", pc, exp_pc);
        chk("end_pc4", pc_plus4, exp_pc + 32'd4);
        chk("end_instr", Instr, exp_instr);
        m_pc    = exp_pc;
        m_instr = exp_instr;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t rv;
        int   upper;

        // ld tgt lat mid_ld mid_at mid_tgt rdata exp_addr exp_pc
        tbl[0] = '{1'b0, 32'h0,         0,  1'b0, 0, 32'h0,   32'h2008_0005, 32'h0000_0000, 32'h0000_0004};
        tbl[1] = '{1'b0, 32'h0,         5,  1'b0, 0, 32'h0,   32'h8C01_0004, 32'h0000_0004, 32'h0000_0008};
        tbl[2] = '{1'b0, 32'h0,         20, 1'b0, 0, 32'h0,   32'hAAAA_AAAA, 32'h0000_0008, 32'h0000_0008};
        tbl[3] = '{1'b1, 32'h0000_0103, 0,  1'b0, 0, 32'h0,   32'h1111_1111, 32'h0000_0100, 32'h0000_0104};
        tbl[4] = '{1'b0, 32'h0,         2,  1'b1, 1, 32'h400, 32'h2222_2222, 32'h0000_0104, 32'h0000_0400};
        tbl[5] = '{1'b1, 32'hFFFF_FFFC, 0,  1'b0, 0, 32'h0,   32'h3333_3333, 32'hFFFF_FFFC, 32'h0000_0000};
        tbl[6] = '{1'b0, 32'h0,         99, 1'b1, 3, 32'h202, 32'h4444_4444, 32'h0000_0000, 32'h0000_0200};

        reset         = 1'b1;
        fetch_req     = 1'b0;
        pc_load       = 1'b0;
        pc_next       = 32'h0;
        imem_if.ready = 1'b0;
        imem_if.rdata = 32'h0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_pc", pc, RST_PC);
        chk("rst_instr", Instr, 0);
        chk("rst_req", imem_if.req, 0);
        chk("rst_addr", imem_if.addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_err", fetch_err, 0);
        m_pc    = RST_PC;
        m_instr = 32'h0;

        foreach (tbl[i]) do_fetch(tbl[i], 1'b1);

        // ready with no request outstanding changes nothing.
        for (int i = 0; i < 3; i++) begin
            imem_if.ready = 1'b1;
            imem_if.rdata = $urandom;
            @(negedge clk);
            #1;
            chk("stray_ready_busy", busy, 0);
            chk("stray_ready_valid", instr_valid, 0);
            chk("stray_ready_instr", Instr, m_instr);
        end
        imem_if.ready = 1'b0;

        // pc_load in IDLE without a fetch.
        pc_load = 1'b1;
        pc_next = 32'h0000_0ABE;
        #1;
        chk("idle_load_align", align_err, 1);
        @(negedge clk);
        pc_load = 1'b0;
        #1;
        chk("idle_load_pc", pc, 32'h0000_0ABC);
        chk("idle_load_busy", busy, 0);
        m_pc = 32'h0000_0ABC;

        // Reset in REQ with a ready arriving in the same cycle.
        fetch_req = 1'b1;
        @(negedge clk);
        fetch_req = 1'b0;
        #1;
        chk("pre_rst_req", imem_if.req, 1);
        imem_if.ready = 1'b1;
        imem_if.rdata = 32'hDEAD_BEEF;
        reset         = 1'b1;
        @(negedge clk);
        reset         = 1'b0;
        imem_if.ready = 1'b0;
        #1;
        chk("midrst_instr", Instr, 0);
        chk("midrst_pc", pc, RST_PC);
        chk("midrst_valid", instr_valid, 0);
        chk("midrst_req", imem_if.req, 0);
        chk("midrst_busy", busy, 0);
        @(negedge clk);
        #1;
        chk("midrst_valid2", instr_valid, 0);
        m_pc    = RST_PC;
        m_instr = 32'h0;

        for (int n = 0; n < 40; n++) begin
            rv.ld      = ($urandom % 3 == 0);
            rv.tgt     = $urandom;
            rv.lat     = ($urandom % 4 == 0) ? WAIT_MAX + int'($urandom % 4) : int'($urandom_range(0, 6));
            rv.mid_ld  = ($urandom % 3 == 0);
            upper      = (rv.lat < WAIT_MAX) ? rv.lat : WAIT_MAX - 1;
            rv.mid_at  = int'($urandom_range(0, upper));
            rv.mid_tgt = $urandom;
            rv.rdata   = $urandom;
            rv.exp_addr = 32'h0;
            rv.exp_pc   = 32'h0;
            do_fetch(rv, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
